// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: ALU control codes and sequencer state encoding shared by the multiply/divide slice
package muldiv_seq_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/muldiv_seq_div_step.sv
// div_step: one combinational restoring-division iteration
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            qbit
);
  logic [XLEN-1:0] shifted;
  always_comb begin
    shifted  = {rem[XLEN-2:0], msb};
    qbit     = shifted >= divisor;
    rem_next = qbit ? shifted - divisor : shifted;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider that stalls the pipeline while running
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a, b, acc, rem, rem_next, sum, quot;
  logic            qbit, accept, last;
  div_step #(.XLEN(XLEN)) u_step (
    .rem(rem),
    .msb(a[XLEN-1]),
    .divisor(b),
    .rem_next(rem_next),
    .qbit(qbit)
  );
  always_comb begin
    accept = state == IDLE && start && (alucontrol == ALU_MUL || alucontrol == ALU_DIV);
    last   = cnt == CW'(1);
    sum    = b[0] ? acc + a : acc;
    quot   = {acc[XLEN-2:0], qbit};
    busy   = state == MUL || state == DIV;
    done   = state == DONE;
    stall  = busy || accept;
  end
  // a holds multiplicand/dividend, b multiplier/divisor, acc product/quotient
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a   <= srca;
          b   <= srcb;
          acc <= '0;
          rem <= '0;
          cnt <= CW'(XLEN);
          if (alucontrol == ALU_DIV && srcb == '0) begin
            state  <= DONE;
            result <= '1;
          end else begin
            state <= alucontrol == ALU_MUL ? MUL : DIV;
          end
        end
        MUL: begin
          acc <= sum;
          a   <= a << 1;
          b   <= b >> 1;
          cnt <= cnt - CW'(1);
          if (last) begin
            state  <= DONE;
            result <= sum;
          end
        end
        DIV: begin
          rem <= rem_next;
          a   <= a << 1;
          acc <= quot;
          cnt <= cnt - CW'(1);
          if (last) begin
            state  <= DONE;
            result <= quot;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
